// File: rtl/uart_tx_gen.sv
// rtl/uart_tx_gen.sv - parameterised UART transmitter with optional parity and 1/2 stop bits
module uart_tx_gen #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 1,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 tx_start,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
            PARITY < 0 || PARITY > 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
            $error("uart_tx_gen: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bit;
    logic                 stop_last;
    logic                 bit_end;

    assign stop_last = (STOP_BITS == 1) || stop_idx;
    assign bit_end   = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (tx_start) begin
                        shift_reg  <= data;
                        parity_bit <= (PARITY == 2) ? ~^data : ^data;
                        state      <= ST_START;
                        tx         <= 1'b0;
                        tx_busy    <= 1'b1;
                        cnt        <= '0;
                        bit_idx    <= '0;
                        stop_idx   <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        cnt       <= '0;
                        state     <= ST_DATA;
                        tx        <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == IDX_LAST) begin
                            if (PARITY != 0) begin
                                state <= ST_PARITY;
                                tx    <= parity_bit;
                            end else begin
                                state <= ST_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            tx        <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= ST_STOP;
                        tx    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    tx <= 1'b1;
                    // Registered one cycle early so the pulse lands on the final stop cycle
                    if (cnt == CNT_PRE && stop_last) begin
                        tx_done <= 1'b1;
                    end
                    if (bit_end) begin
                        cnt <= '0;
                        if (stop_last) begin
                            state   <= ST_IDLE;
                            tx_busy <= 1'b0;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_gen.sv
// tb/tb_uart_tx_gen.sv - directed bench for uart_tx_gen in 8E1, 8O2 and 7N1 at 4 clocks per bit
module tb_uart_tx_gen;

    logic       clk;
    logic       reset;
    logic [7:0] data0;
    logic [7:0] data1;
    logic [6:0] data2;
    logic       start_r [3];
    logic       tx_w    [3];
    logic       busy_w  [3];
    logic       done_w  [3];

    int vectors;
    int miscompares;

    uart_tx_gen #(.CLK_FREQ(40), .BAUD_RATE(10), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .reset(reset), .data(data0), .tx_start(start_r[0]),
        .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0])
    );

    uart_tx_gen #(.CLK_FREQ(40), .BAUD_RATE(10), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_8o2 (
        .clk(clk), .reset(reset), .data(data1), .tx_start(start_r[1]),
        .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1])
    );

    uart_tx_gen #(.CLK_FREQ(40), .BAUD_RATE(10), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1)) u_7n1 (
        .clk(clk), .reset(reset), .data(data2), .tx_start(start_r[2]),
        .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int k, input logic [8:0] d);
        case (k)
            0:       data0 = d[7:0];
            1:       data1 = d[7:0];
            default: data2 = d[6:0];
        endcase
    endtask

    // Presents a request for one cycle (or leaves it held) and returns in cycle 1 of the frame
    task automatic start_frame(input int k, input logic [8:0] d, input logic hold);
        set_data(k, d);
        start_r[k] = 1'b1;
        step();
        if (!hold) start_r[k] = 1'b0;
    endtask

    // bits[0] is the start bit; each bit lasts 4 cycles; returns in the cycle after the frame
    task automatic check_frame(input int k, input logic [11:0] bits, input int nbits,
                               input logic change_mid, input logic [8:0] mid_data);
        for (int c = 1; c <= nbits * 4; c++) begin
            chk($sformatf("tx[%0d] c%0d", k, c), tx_w[k], bits[(c - 1) / 4]);
            chk($sformatf("busy[%0d] c%0d", k, c), busy_w[k], 1'b1);
            chk($sformatf("done[%0d] c%0d", k, c), done_w[k], (c == nbits * 4));
            if (change_mid && c == 10) set_data(k, mid_data);
            step();
        end
        chk($sformatf("busy_after[%0d]", k), busy_w[k], 1'b0);
        chk($sformatf("tx_after[%0d]", k), tx_w[k], 1'b1);
        chk($sformatf("done_after[%0d]", k), done_w[k], 1'b0);
    endtask

    initial begin
        logic done_seen;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        data0       = '0;
        data1       = '0;
        data2       = '0;
        for (int i = 0; i < 3; i++) start_r[i] = 1'b0;
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_tx[%0d]", i), tx_w[i], 1'b1);
            chk($sformatf("reset_busy[%0d]", i), busy_w[i], 1'b0);
            chk($sformatf("reset_done[%0d]", i), done_w[i], 1'b0);
        end
        reset = 1'b0;
        step();
        chk("idle_tx0", tx_w[0], 1'b1);

        // 8E1 0xA5: start, 1,0,1,0,0,1,0,1, parity 0, stop
        start_frame(0, 9'h0A5, 1'b0);
        check_frame(0, 12'b0_1_0_10100101_0, 11, 1'b0, 9'h0);

        // 8O2 0xA5: parity 1, two stop bits, 48 cycles
        start_frame(1, 9'h0A5, 1'b0);
        check_frame(1, 12'b1_1_1_10100101_0, 12, 1'b0, 9'h0);

        // 7N1 0x41: 9 bits, 36 cycles, stop right after bit 6
        start_frame(2, 9'h041, 1'b0);
        check_frame(2, 12'b000_1_1000001_0, 9, 1'b0, 9'h0);

        // tx_start held: 0x3C in flight, 0xC3 presented mid-frame, sent only as the next frame
        start_frame(0, 9'h03C, 1'b1);
        check_frame(0, 12'b0_1_0_00111100_0, 11, 1'b1, 9'h0C3);
        step();
        start_r[0] = 1'b0;
        check_frame(0, 12'b0_1_0_11000011_0, 11, 1'b0, 9'h0);

        // Reset in cycle 10 of an 8E1 frame; request on idle u_8o2 during reset is not accepted
        start_frame(0, 9'h0A5, 1'b0);
        for (int c = 1; c < 10; c++) step();
        chk("pre_reset_busy", busy_w[0], 1'b1);
        reset      = 1'b1;
        start_r[1] = 1'b1;
        step();
        reset      = 1'b0;
        start_r[1] = 1'b0;
        chk("abort_tx", tx_w[0], 1'b1);
        chk("abort_busy", busy_w[0], 1'b0);
        chk("abort_done", done_w[0], 1'b0);
        chk("no_accept_in_reset", busy_w[1], 1'b0);
        done_seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            done_seen = done_seen | done_w[0] | busy_w[1];
            step();
        end
        chk("no_done_after_abort", done_seen, 1'b0);

        start_frame(0, 9'h0A5, 1'b0);
        check_frame(0, 12'b0_1_0_10100101_0, 11, 1'b0, 9'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
